spike_rate_decoder: RTL and testbench

// - Output-side reader of the neuron layer. Consumes per-timestep is_spike vectors from N neurons over a programmable window.
// - Keeps a saturating spike count per neuron and picks the winner (highest count) by a serial arg-max.
// - Presents counts + winner to the host/IO logic through a valid/ready handshake. Sits between the neuron array and the chip output mux.

---
 rtl/spike_rate_decoder_pkg.sv | 17 +
 rtl/spike_counter_sat.sv | 30 +++
 rtl/spike_rate_decoder.sv | 152 +++++++++++++++
 tb/tb_spike_rate_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/spike_rate_decoder_pkg.sv
// Shared types and default widths for the spike rate decoder slice.
package spike_rate_decoder_pkg;

  // Default widths shared with the neuron layer.
  localparam int DEF_N_NEURONS = 4;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_WIN_W     = 8;

  // Decoder FSM encoding. The numeric values are exposed on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/spike_counter_sat.sv
// Per-neuron saturating spike counter: clears on request, otherwise
// increments on inc and sticks at the all-ones value instead of wrapping.
module spike_counter_sat #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;

  // Count accepted spikes; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/spike_rate_decoder.sv
// Output-side reader of the neuron layer. Counts spikes per neuron over a
// programmable window, finds the most active neuron with a serial arg-max
// and offers counts + winner to the host with a valid/ready handshake.
//
// Handshake: result_valid rises once the scan finishes and stays high with
// counts/winner/no_spike frozen until a rising clk edge sees
// result_valid & result_ready; result_valid is low from the next cycle on.
module spike_rate_decoder
  import spike_rate_decoder_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int WIN_W     = DEF_WIN_W,
  localparam int IDX_W    = $clog2(N_NEURONS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [WIN_W-1:0]          window_len,
  input  logic                      step_valid,
  input  logic [N_NEURONS-1:0]      spikes,
  output logic                      busy,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [N_NEURONS*CNT_W-1:0] counts,
  output logic [IDX_W-1:0]          winner,
  output logic                      no_spike,
  output logic [1:0]                o_dbg_state
);

  state_t r_state;
  state_t w_next_state;

  logic [WIN_W-1:0] r_steps_left;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_best_idx;
  logic [CNT_W-1:0] r_best_val;
  logic [IDX_W-1:0] r_winner;
  logic             r_no_spike;

  logic [CNT_W-1:0] w_cnt [N_NEURONS];
  logic             w_start_accept;
  logic             w_step_accept;
  logic             w_last_step;
  logic             w_scan_last;
  logic [CNT_W-1:0] w_scan_val;
  logic             w_scan_gt;

  assign w_start_accept = (r_state == ST_IDLE) && start;
  assign w_step_accept  = (r_state == ST_ACCUM) && step_valid;
  assign w_last_step    = w_step_accept && (r_steps_left == WIN_W'(1));
  assign w_scan_last    = (r_state == ST_ARGMAX) && (r_idx == IDX_W'(N_NEURONS - 1));
  assign w_scan_val     = w_cnt[r_idx];
  // Strictly greater only: ties (including saturated counts) keep the lower index.
  assign w_scan_gt      = w_scan_val > r_best_val;

  // One saturating counter per neuron, cleared when a window is accepted.
  for (genvar g = 0; g < N_NEURONS; g++) begin : g_cnt
    spike_counter_sat #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (w_start_accept),
      .inc   (w_step_accept && spikes[g]),
      .count (w_cnt[g])
    );
    assign counts[g*CNT_W +: CNT_W] = w_cnt[g];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (start)                       w_next_state = ST_ACCUM;
      ST_ACCUM:  if (w_last_step)                 w_next_state = ST_ARGMAX;
      ST_ARGMAX: if (w_scan_last)                 w_next_state = ST_HOLD;
      ST_HOLD:   if (result_ready)                w_next_state = ST_IDLE;
      default:                                    w_next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy         = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      ST_ACCUM:  busy         = 1'b1;
      ST_ARGMAX: busy         = 1'b1;
      ST_HOLD:   result_valid = 1'b1;
      default: begin
        busy         = 1'b0;
        result_valid = 1'b0;
      end
    endcase
  end

  // Window length tracking; a zero length still runs a single step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_steps_left <= '0;
    end else if (w_start_accept) begin
      r_steps_left <= (window_len == '0) ? WIN_W'(1) : window_len;
    end else if (w_step_accept) begin
      r_steps_left <= r_steps_left - WIN_W'(1);
    end
  end

  // Serial arg-max scan, one neuron per cycle, armed by the last step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_best_idx <= '0;
      r_best_val <= '0;
    end else if (w_last_step) begin
      r_idx      <= '0;
      r_best_idx <= '0;
      r_best_val <= '0;
    end else if (r_state == ST_ARGMAX) begin
      if (w_scan_gt) begin
        r_best_val <= w_scan_val;
        r_best_idx <= r_idx;
      end
      if (!w_scan_last) begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  // Result registers, written once as the scan completes and frozen in HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_winner   <= '0;
      r_no_spike <= 1'b0;
    end else if (w_scan_last) begin
      r_winner   <= w_scan_gt ? r_idx : r_best_idx;
      r_no_spike <= (w_scan_gt ? w_scan_val : r_best_val) == '0;
    end
  end

  assign winner      = r_winner;
  assign no_spike    = r_no_spike;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder. Two instances share stimulus:
// one with 8-bit counters, one with 4-bit counters to exercise saturation.
module tb_spike_rate_decoder;

  localparam int N   = 4;
  localparam int CW  = 8;
  localparam int CW4 = 4;
  localparam int WW  = 8;
  localparam int RW  = 3 + N*CW;
  localparam int RW4 = 3 + N*CW4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [WW-1:0] window_len = '0;
  logic          step_valid = 1'b0;
  logic [N-1:0]  spikes = '0;
  logic          result_ready = 1'b0;

  logic            busy_a, rv_a, no_spike_a;
  logic [N*CW-1:0] counts_a;
  logic [1:0]      winner_a, state_a;
  logic             busy_b, rv_b, no_spike_b;
  logic [N*CW4-1:0] counts_b;
  logic [1:0]       winner_b, state_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [RW-1:0]  exp_q[$];
  logic [RW4-1:0] exp4_q[$];
  logic [N-1:0]   stim_q[$];

  spike_rate_decoder #(.N_NEURONS(N), .CNT_W(CW), .WIN_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .window_len(window_len),
    .step_valid(step_valid), .spikes(spikes), .busy(busy_a),
    .result_valid(rv_a), .result_ready(result_ready), .counts(counts_a),
    .winner(winner_a), .no_spike(no_spike_a), .o_dbg_state(state_a)
  );

  spike_rate_decoder #(.N_NEURONS(N), .CNT_W(CW4), .WIN_W(WW)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .window_len(window_len),
    .step_valid(step_valid), .spikes(spikes), .busy(busy_b),
    .result_valid(rv_b), .result_ready(result_ready), .counts(counts_b),
    .winner(winner_b), .no_spike(no_spike_b), .o_dbg_state(state_b)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain sums per neuron, clipped at the counter maximum; the
  // winner is the lowest index holding the maximum count.
  function automatic logic [63:0] model_pack(input int cw);
    int sum [N];
    int maxv, m, win;
    logic [63:0] r;
    maxv = (1 << cw) - 1;
    for (int i = 0; i < N; i++) sum[i] = 0;
    foreach (stim_q[k]) for (int i = 0; i < N; i++) sum[i] += int'(stim_q[k][i]);
    for (int i = 0; i < N; i++) if (sum[i] > maxv) sum[i] = maxv;
    m = 0;
    for (int i = 0; i < N; i++) if (sum[i] > m) m = sum[i];
    win = 0;
    for (int i = N-1; i >= 0; i--) if (sum[i] == m) win = i;
    r = '0;
    for (int i = 0; i < N; i++) r |= 64'(sum[i]) << (i*cw);
    r |= 64'(win) << (N*cw);
    r |= 64'(m == 0) << (N*cw + 2);
    return r;
  endfunction

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) step_cycle();
    rst_n = 1'b1;
  endtask

  // Drive one window from stim_q, check latency, result and handshake.
  task automatic run_window(input int len, input int max_stall, input int hold, input string tag);
    logic [RW-1:0]  ea;
    logic [RW4-1:0] eb;
    exp_q.push_back(RW'(model_pack(CW)));
    exp4_q.push_back(RW4'(model_pack(CW4)));
    start = 1'b1;
    window_len = WW'(len);
    step_cycle();
    start = 1'b0;
    window_len = WW'($urandom);
    check({tag, " busy"}, 64'(busy_a), 64'(1));
    foreach (stim_q[k]) begin
      repeat ($urandom_range(max_stall, 0)) begin
        step_valid = 1'b0;
        spikes = N'($urandom);
        step_cycle();
      end
      step_valid = 1'b1;
      spikes = stim_q[k];
      step_cycle();
      step_valid = 1'b0;
      spikes = N'($urandom);
    end
    for (int c = 0; c < N; c++) begin
      check({tag, " early_valid"}, 64'(rv_a), 64'(0));
      step_cycle();
    end
    check({tag, " valid_a"}, 64'(rv_a), 64'(1));
    check({tag, " valid_b"}, 64'(rv_b), 64'(1));
    ea = exp_q.pop_front();
    eb = exp4_q.pop_front();
    check({tag, " result_a"}, 64'({no_spike_a, winner_a, counts_a}), 64'(ea));
    check({tag, " result_b"}, 64'({no_spike_b, winner_b, counts_b}), 64'(eb));
    for (int h = 0; h < hold; h++) begin
      result_ready = 1'b0;
      start = 1'($urandom);
      step_valid = 1'($urandom);
      spikes = N'($urandom);
      step_cycle();
      check({tag, " hold_valid"}, 64'(rv_a), 64'(1));
      check({tag, " hold_a"}, 64'({no_spike_a, winner_a, counts_a}), 64'(ea));
      check({tag, " hold_b"}, 64'({no_spike_b, winner_b, counts_b}), 64'(eb));
    end
    result_ready = 1'b1;
    start = 1'b1;
    step_valid = 1'b1;
    step_cycle();
    result_ready = 1'b0;
    start = 1'b0;
    step_valid = 1'b0;
    check({tag, " done_valid"}, 64'({rv_a, rv_b}), 64'(0));
    check({tag, " done_busy"}, 64'({busy_a, busy_b}), 64'(0));
    check({tag, " done_state"}, 64'({state_a, state_b}), 64'(0));
    stim_q.delete();
  endtask

  initial begin
    int len, eff;
    do_reset(3);
    check("reset_busy", 64'({busy_a, busy_b}), 64'(0));
    check("reset_valid", 64'({rv_a, rv_b}), 64'(0));
    check("reset_counts_a", 64'(counts_a), 64'(0));
    check("reset_counts_b", 64'(counts_b), 64'(0));
    check("reset_outs", 64'({winner_a, no_spike_a, winner_b, no_spike_b}), 64'(0));
    check("reset_state", 64'({state_a, state_b}), 64'(0));

    // Basic window, no stalls.
    stim_q = '{4'b0001, 4'b0011, 4'b0010, 4'b0010, 4'b1010};
    run_window(5, 0, 2, "basic");

    // Tie between neurons 1 and 2 with stall cycles between steps.
    stim_q = '{4'b0110, 4'b0110, 4'b0110};
    run_window(3, 3, 1, "tie");

    // Saturation, then two zero-length windows restart from zero.
    for (int k = 0; k < 255; k++) stim_q.push_back(4'hF);
    run_window(255, 0, 1, "sat255");
    stim_q = '{4'hF};
    run_window(0, 1, 1, "len0_a");
    stim_q = '{4'hF};
    run_window(0, 0, 1, "len0_b");

    // Neuron 2 only: 4-bit instance clips at 15, 8-bit instance reads 20.
    for (int k = 0; k < 20; k++) stim_q.push_back(4'b0100);
    run_window(20, 1, 1, "sat4");

    // Result held for 10 cycles with start/step_valid noise.
    stim_q = '{4'b1000, 4'b1001};
    run_window(2, 0, 10, "hold10");

    // Empty window.
    stim_q = '{4'b0000, 4'b0000};
    run_window(2, 1, 1, "empty");

    // Reset in the middle of a window aborts it.
    start = 1'b1;
    window_len = WW'(10);
    step_cycle();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step_valid = 1'b1;
      spikes = 4'hF;
      step_cycle();
    end
    step_valid = 1'b0;
    check("mid_accum_busy", 64'(busy_a), 64'(1));
    do_reset(2);
    check("abort_busy", 64'({busy_a, busy_b}), 64'(0));
    check("abort_valid", 64'({rv_a, rv_b}), 64'(0));
    check("abort_counts", 64'({counts_a, counts_b}), 64'(0));
    check("abort_state", 64'({state_a, state_b}), 64'(0));
    step_cycle();
    stim_q = '{4'b0100, 4'b0101};
    run_window(2, 1, 1, "after_reset");

    // Random windows.
    for (int w = 0; w < 25; w++) begin
      len = $urandom_range(12, 0);
      eff = (len == 0) ? 1 : len;
      for (int k = 0; k < eff; k++) stim_q.push_back(N'($urandom));
      run_window(len, 2, $urandom_range(3, 0), $sformatf("rand%0d", w));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
